// File: rtl/yarp_branch_predict_unit.sv
// B-type branch resolver with a PC-indexed 2-bit BHT and saturating perf counters.
// Prediction is combinational; resolve pulses, BHT and counters update one edge after accept. There is no backpressure.
module yarp_branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetch_pc_i,
  output logic             pred_taken_o,
  input  logic             ex_valid_i,
  input  logic             ex_flush_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             ex_pred_taken_i,
  input  logic             is_b_type_ctl_i,
  input  logic [2:0]       instr_func3_ctl_i,
  input  logic [XLEN-1:0]  opr_a_i,
  input  logic [XLEN-1:0]  opr_b_i,
  output logic             resolve_valid_o,
  output logic             branch_taken_o,
  output logic             mispredict_o,
  output logic             illegal_func3_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             acc;
  logic             legal;
  logic             outcome;
  logic             upd;
  logic             mispred;
  logic [1:0]       cur_cnt;
  logic [1:0]       nxt_cnt;
  logic             unused_pc_bits;

  assign fetch_idx    = fetch_pc_i[IDX_W+1:2];
  assign ex_idx       = ex_pc_i[IDX_W+1:2];
  assign pred_taken_o = bht[fetch_idx][1];

  // Untagged table: upper PC bits and the byte offset never take part in lookup.
  assign unused_pc_bits = ^{fetch_pc_i[XLEN-1:IDX_W+2], fetch_pc_i[1:0],
                            ex_pc_i[XLEN-1:IDX_W+2], ex_pc_i[1:0]};

  assign acc = ex_valid_i & ~ex_flush_i & is_b_type_ctl_i;

  always_comb begin
    outcome = 1'b0;
    legal   = 1'b1;
    case (instr_func3_ctl_i)
      F3_BEQ:  outcome = (opr_a_i == opr_b_i);
      F3_BNE:  outcome = (opr_a_i != opr_b_i);
      F3_BLT:  outcome = ($signed(opr_a_i) <  $signed(opr_b_i));
      F3_BGE:  outcome = ($signed(opr_a_i) >= $signed(opr_b_i));
      F3_BLTU: outcome = (opr_a_i <  opr_b_i);
      F3_BGEU: outcome = (opr_a_i >= opr_b_i);
      default: legal   = 1'b0;
    endcase
  end

  assign upd     = acc & legal;
  assign mispred = outcome != ex_pred_taken_i;
  assign cur_cnt = bht[ex_idx];

  always_comb begin
    nxt_cnt = cur_cnt;
    if (outcome) begin
      if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'b01;
    end else begin
      if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      resolve_valid_o <= 1'b0;
      branch_taken_o  <= 1'b0;
      mispredict_o    <= 1'b0;
      illegal_func3_o <= 1'b0;
      branch_cnt_o    <= '0;
      mispred_cnt_o   <= '0;
    end else begin
      resolve_valid_o <= upd;
      branch_taken_o  <= upd & outcome;
      mispredict_o    <= upd & mispred;
      illegal_func3_o <= acc & ~legal;
      if (upd) bht[ex_idx] <= nxt_cnt;
      if (upd && branch_cnt_o != CNT_MAX) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (upd && mispred && mispred_cnt_o != CNT_MAX) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_yarp_branch_predict_unit.sv
// Directed bench for yarp_branch_predict_unit: a reference BHT/counter model fills a
// scoreboard queue as each step is driven, and entries are popped after the edge.
module tb_yarp_branch_predict_unit;

  localparam int NE = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc_i = '0;
  logic        pred_taken_o;
  logic        ex_valid_i = 1'b0;
  logic        ex_flush_i = 1'b0;
  logic [31:0] ex_pc_i = '0;
  logic        ex_pred_taken_i = 1'b0;
  logic        is_b_type_ctl_i = 1'b0;
  logic [2:0]  instr_func3_ctl_i = '0;
  logic [31:0] opr_a_i = '0;
  logic [31:0] opr_b_i = '0;
  logic        resolve_valid_o;
  logic        branch_taken_o;
  logic        mispredict_o;
  logic        illegal_func3_o;
  logic [3:0]  branch_cnt_o;
  logic [3:0]  mispred_cnt_o;

  always #5 clk = ~clk;

  yarp_branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(NE), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_pc_i(fetch_pc_i), .pred_taken_o(pred_taken_o),
    .ex_valid_i(ex_valid_i), .ex_flush_i(ex_flush_i), .ex_pc_i(ex_pc_i),
    .ex_pred_taken_i(ex_pred_taken_i), .is_b_type_ctl_i(is_b_type_ctl_i),
    .instr_func3_ctl_i(instr_func3_ctl_i), .opr_a_i(opr_a_i), .opr_b_i(opr_b_i),
    .resolve_valid_o(resolve_valid_o), .branch_taken_o(branch_taken_o),
    .mispredict_o(mispredict_o), .illegal_func3_o(illegal_func3_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  typedef struct packed {
    logic       rv;
    logic       tk;
    logic       mp;
    logic       il;
    logic [3:0] bc;
    logic [3:0] mc;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mdl [NE];
  logic [3:0] m_bc;
  logic [3:0] m_mc;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  // One clock step: drive, check the combinational prediction before the edge,
  // update the model as the edge would, then compare the registered outputs.
  task automatic drive(input bit rst, input bit v, input bit fl, input bit bt,
                       input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input bit pred);
    exp_t e;
    bit   acc, legal, tk;
    exp_t got;
    reset = rst; ex_valid_i = v; ex_flush_i = fl; is_b_type_ctl_i = bt;
    instr_func3_ctl_i = f3; ex_pc_i = pc; opr_a_i = a; opr_b_i = b; ex_pred_taken_i = pred;
    #1;
    if (!rst) check("pred_pre_edge", {31'b0, pred_taken_o}, {31'b0, mdl[idx_of(fetch_pc_i)][1]});
    acc   = v && !fl && bt;
    legal = !(f3 == 3'b010 || f3 == 3'b011);
    case (f3)
      3'b000:  tk = (a == b);
      3'b001:  tk = (a != b);
      3'b100:  tk = ($signed(a) <  $signed(b));
      3'b101:  tk = ($signed(a) >= $signed(b));
      3'b110:  tk = (a <  b);
      3'b111:  tk = (a >= b);
      default: tk = 1'b0;
    endcase
    e = '0;
    if (rst) begin
      for (int i = 0; i < NE; i++) mdl[i] = 2'b01;
      m_bc = '0; m_mc = '0;
    end else begin
      if (acc && legal) begin
        e.rv = 1'b1; e.tk = tk; e.mp = (tk != pred);
        if (tk && mdl[idx_of(pc)] != 2'b11) mdl[idx_of(pc)] = mdl[idx_of(pc)] + 2'b01;
        if (!tk && mdl[idx_of(pc)] != 2'b00) mdl[idx_of(pc)] = mdl[idx_of(pc)] - 2'b01;
        if (m_bc != 4'hF) m_bc = m_bc + 4'd1;
        if (e.mp && m_mc != 4'hF) m_mc = m_mc + 4'd1;
      end
      e.il = acc && !legal;
    end
    e.bc = m_bc; e.mc = m_mc;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      got = '{resolve_valid_o, branch_taken_o, mispredict_o, illegal_func3_o, branch_cnt_o, mispred_cnt_o};
      check("resolve_valid", {31'b0, got.rv}, {31'b0, e.rv});
      check("branch_taken",  {31'b0, got.tk}, {31'b0, e.tk});
      check("mispredict",    {31'b0, got.mp}, {31'b0, e.mp});
      check("illegal_func3", {31'b0, got.il}, {31'b0, e.il});
      check("branch_cnt",    {28'b0, got.bc}, {28'b0, e.bc});
      check("mispred_cnt",   {28'b0, got.mc}, {28'b0, e.mc});
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic sweep_pred(input string tag);
    for (int i = 0; i < NE; i++) begin
      fetch_pc_i = 32'(i * 4) | 32'h0000_1001;
      #1;
      check(tag, {31'b0, pred_taken_o}, {31'b0, mdl[i][1]});
    end
  endtask

  initial begin
    for (int i = 0; i < NE; i++) mdl[i] = 2'b11;
    m_bc = '0; m_mc = '0;

    // Reset and power-on table contents.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    sweep_pred("pred_after_reset");
    idle();

    // Signed vs unsigned compare on the same operands.
    fetch_pc_i = 32'h100;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 32'h100, 32'h8000_0000, 32'h0000_0001, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 32'h100, 32'h8000_0000, 32'h0000_0001, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 32'h104, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 32'h104, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

    // Back-to-back taken BEQ at 0x40 with a same-cycle lookup of that index.
    fetch_pc_i = 32'h40;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'd5, 32'd5, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'd5, 32'd5, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'd5, 32'd5, 1'b1);
    // Four not-taken BNE walk the counter down to strongly not-taken.
    for (int k = 0; k < 4; k++)
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 32'h40, 32'd7, 32'd7, 1'b1);
    // One taken from 00 must still predict not-taken.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'd9, 32'd9, 1'b0);
    idle();

    // Flushed branch, illegal funct3, non-B-type: nothing but the illegal pulse.
    fetch_pc_i = 32'h80;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h80, 32'd1, 32'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h80, 32'd1, 32'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h80, 32'd1, 32'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h80, 32'd1, 32'd1, 1'b0);
    idle();
    sweep_pred("pred_after_kills");

    // Counter saturation at 0xF, then reset coinciding with an accepted branch.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 17; k++)
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'(k * 4), 32'd3, 32'd3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'd3, 32'd3, 1'b0);
    sweep_pred("pred_after_midreset");
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yarp_branch_predict_unit.md
Name: yarp_branch_predict_unit

Overview:
Parametrised successor to the combinational branch comparator. It resolves B-type branch conditions at XLEN width and registers the outcome. It also holds a PC-indexed table of 2-bit saturating counters (BHT) that provides a taken/not-taken prediction to fetch, and it flags mispredicts to the pipeline control. Two saturating performance counters track resolved branches and mispredicts.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of BHT counters; power of two, >= 2; IDX_W = log2(BHT_ENTRIES)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
fetch_pc_i  in  XLEN  PC being fetched; BHT lookup address
pred_taken_o  out  1  combinational prediction for fetch_pc_i
ex_valid_i  in  1  execute-stage instruction valid
ex_flush_i  in  1  execute-stage instruction is on the wrong path; kill it
ex_pc_i  in  XLEN  PC of the execute-stage instruction
ex_pred_taken_i  in  1  prediction that was made for this instruction at fetch
is_b_type_ctl_i  in  1  execute-stage instruction is B-type
instr_func3_ctl_i  in  3  branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU from yarp_pkg)
opr_a_i  in  XLEN  rs1 value
opr_b_i  in  XLEN  rs2 value
resolve_valid_o  out  1  registered; a branch resolved last cycle
branch_taken_o  out  1  registered actual outcome
mispredict_o  out  1  registered; outcome != ex_pred_taken_i
illegal_func3_o  out  1  registered one-cycle pulse for B-type with funct3 010 or 011
branch_cnt_o  out  CNT_W  resolved-branch count
mispred_cnt_o  out  CNT_W  mispredict count

Behaviour:
- Accept condition: acc = ex_valid_i & ~ex_flush_i & is_b_type_ctl_i.
- Compares: BEQ/BNE use equality. BLT/BGE use true signed XLEN two's-complement compare, so 0x8000_0000 < 0x0000_0001 is true. BLTU/BGEU use unsigned compare.
- Legal funct3 = {000, 001, 100, 101, 110, 111}.
- Index: idx = pc[IDX_W+1:2]. PC bits [1:0] are ignored. There is no tag, so aliasing is permitted.
- Prediction: pred_taken_o = bht[idx(fetch_pc_i)][1]. It is combinational with zero latency.
- Registered outputs (latency 1), driven on the edge after the accept cycle:
  - acc and legal: resolve_valid_o=1; branch_taken_o=outcome; mispredict_o=(outcome != ex_pred_taken_i); illegal_func3_o=0.
  - acc and illegal: resolve_valid_o=0, branch_taken_o=0, mispredict_o=0, illegal_func3_o=1. There is no BHT update and no count.
  - Otherwise (not valid, flushed, or non-B-type): all four outputs are 0 the next cycle. They are single-cycle pulses and never hold.
- BHT update: on the same edge, for acc and legal only.
  - Taken: counter = min(cnt+1, 3).
  - Not taken: counter = max(cnt-1, 0).
  - Encoding: 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T.
- Same-cycle lookup/update to the same index: pred_taken_o reflects the pre-update value. There is no bypass, and the new value is visible from the next cycle.
- Perf counters, on the same edge:
  - branch_cnt_o += 1 on acc and legal.
  - mispred_cnt_o += 1 on acc and legal and mispredict.
  - Both saturate at all-ones. There is no wrap.
- Reset (synchronous, takes priority over all updates):
  - All BHT entries are set to 01.
  - resolve_valid_o, branch_taken_o, mispredict_o, illegal_func3_o, branch_cnt_o and mispred_cnt_o are set to 0.
  - Reset asserted in the same cycle as acc discards that branch: no output pulse, no update.
- ex_flush_i has priority over ex_valid_i. A flushed branch leaves no trace in the outputs, the BHT or the counters.
- Back-to-back branches in consecutive cycles are supported. Each produces its own pulse and update, and consecutive updates to the same index accumulate (01 -> 10 -> 11).

Test Plan:
- Reset, then sweep fetch_pc_i over all indices -> pred_taken_o=0 everywhere (counters at 01); all outputs and counters 0.
- BLT, a=0x8000_0000, b=0x0000_0001, pc=0x100, pred=0 -> next cycle resolve_valid_o=1, branch_taken_o=1, mispredict_o=1; mispred_cnt_o=1. BLTU with the same operands -> taken=0, mispredict_o=0.
- Three taken BEQ (a=b=5) at pc=0x40, back-to-back -> counter 01->10->11->11 (saturates); pred_taken_o for 0x40 becomes 1 after the first update. Four not-taken BNE (a=b) -> counter ends at 00.
- Lookup fetch_pc_i=0x40 in the same cycle as an update of idx(0x40) from 01 to 10 -> pred_taken_o=0 that cycle, 1 the next cycle.
- ex_flush_i=1 with a valid taken BEQ; then funct3=010 with is_b_type=1 -> no resolve_valid_o, no BHT change, counters unchanged; illegal_func3_o pulses once for the 010 case only.
- CNT_W=4: drive 17 mispredicting branches -> branch_cnt_o and mispred_cnt_o hold at 0xF. Assert reset mid-stream -> all counters 0 and BHT back to 01 on the next edge.
